// File: rtl/lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_bank
// Purpose  : Bank of N_CH independent Galois LFSRs sharing one step enable.
//            Each channel keeps its active seed (reset seed or last loaded
//            seed). It flags a wrap when a step lands back on that seed, and
//            it produces a registered stochastic spike by comparing its
//            current state with a per-channel threshold.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      state width, 4..32
//   N_CH       number of channels, 1..16
//   TAPS       Galois feedback mask (maximal-length polynomial for WIDTH)
//   SEED_BASE  reset seed of channel 0; channel i resets to SEED_BASE+i
// Ports
//   clk         in   1               clock
//   rst         in   1               synchronous active-high reset
//   en          in   1               advance every channel one step
//   load_valid  in   1               seed load request
//   load_ready  out  1               load accepted when valid && ready
//   load_ch     in   max(1,clog2(N)) target channel of a load
//   load_seed   in   WIDTH           new seed (zero is replaced by 1)
//   thresh      in   N_CH*WIDTH      per-channel spike threshold
//   value       out  N_CH*WIDTH      current LFSR state per channel
//   spike       out  N_CH            registered (value < thresh) && en
//   wrap        out  N_CH            one-cycle pulse when a period completes
// ============================================================================
module lfsr_bank #(
    parameter int                 WIDTH     = 16,
    parameter int                 N_CH      = 4,
    parameter logic [WIDTH-1:0]   TAPS      = 16'hB400,
    parameter int                 SEED_BASE = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   load_valid,
    output logic                                   load_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] load_ch,
    input  logic [WIDTH-1:0]                       load_seed,
    input  logic [N_CH*WIDTH-1:0]                  thresh,
    output logic [N_CH*WIDTH-1:0]                  value,
    output logic [N_CH-1:0]                        spike,
    output logic [N_CH-1:0]                        wrap
);

    localparam int C_LCW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_bank: WIDTH must be in 4..32");
    end

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("lfsr_bank: N_CH must be in 1..16");
    end

    // ------------------------------------------------------------------
    // Load handshake: ready drops for exactly one cycle after acceptance,
    // so back-to-back requests are taken every other cycle.
    // ------------------------------------------------------------------
    logic             r_load_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_load_seed;

    assign w_accept    = load_valid && r_load_ready;
    // An all-zero state would lock the LFSR up, so a zero seed becomes 1.
    assign w_load_seed = (load_seed == '0) ? WIDTH'(1) : load_seed;
    assign load_ready  = r_load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_ready <= 1'b1;
        end else begin
            r_load_ready <= !w_accept;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel LFSR, seed store, wrap detect and spike comparator
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // The cast truncates the reset seed modulo 2^WIDTH.
        localparam logic [WIDTH-1:0] c_seed = WIDTH'(SEED_BASE + i);

        if (c_seed == '0) begin : g_bad_seed
            $error("lfsr_bank: reset seed of a channel is zero");
        end

        logic [WIDTH-1:0] r_state;
        logic [WIDTH-1:0] r_seed;
        logic             r_spike;
        logic             r_wrap;
        logic [WIDTH-1:0] w_step;
        logic [WIDTH-1:0] w_thr;
        logic             w_load_hit;

        assign w_step     = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
        assign w_thr      = thresh[i*WIDTH +: WIDTH];
        // An out-of-range load_ch matches no channel, so the handshake
        // completes without changing any state.
        assign w_load_hit = w_accept && (load_ch == C_LCW'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_seed;
                r_seed  <= c_seed;
                r_spike <= 1'b0;
                r_wrap  <= 1'b0;
            end else begin
                // The spike compares the state as it stood before this edge.
                r_spike <= en && (r_state < w_thr);
                if (w_load_hit) begin
                    // A load overrides the step and never reports a wrap.
                    r_state <= w_load_seed;
                    r_seed  <= w_load_seed;
                    r_wrap  <= 1'b0;
                end else if (en) begin
                    r_state <= w_step;
                    r_wrap  <= (w_step == r_seed);
                end else begin
                    r_wrap  <= 1'b0;
                end
            end
        end

        assign value[i*WIDTH +: WIDTH] = r_state;
        assign spike[i]                = r_spike;
        assign wrap[i]                 = r_wrap;
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_bank
// Purpose  : Self-checking bench for lfsr_bank. Instance A uses WIDTH=16 and
//            N_CH=3, so load_ch=3 is out of range. Instance B uses WIDTH=4,
//            N_CH=2 and TAPS=4'hC. A behavioural model of A is compared on
//            every cycle. Directed literal checks pin the model and cover B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_bank;

    localparam int W = 16;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A stimulus / observation
    logic           rst, en, load_valid;
    logic [1:0]     load_ch;
    logic [W-1:0]   load_seed;
    logic [N*W-1:0] thresh;
    wire  [N*W-1:0] value;
    wire  [N-1:0]   spike, wrap;
    wire            load_ready;

    // Instance B stimulus / observation
    logic           en_b;
    logic           load_valid_b = 1'b0;
    logic [0:0]     load_ch_b    = 1'b0;
    logic [3:0]     load_seed_b  = 4'h0;
    logic [7:0]     thresh_b     = 8'h00;
    wire  [7:0]     value_b;
    wire  [1:0]     spike_b, wrap_b;
    wire            load_ready_b;

    lfsr_bank #(.WIDTH(W), .N_CH(N), .TAPS(16'hB400), .SEED_BASE(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid),
        .load_ready(load_ready), .load_ch(load_ch), .load_seed(load_seed),
        .thresh(thresh), .value(value), .spike(spike), .wrap(wrap)
    );

    lfsr_bank #(.WIDTH(4), .N_CH(2), .TAPS(4'hC), .SEED_BASE(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load_valid(load_valid_b),
        .load_ready(load_ready_b), .load_ch(load_ch_b), .load_seed(load_seed_b),
        .thresh(thresh_b), .value(value_b), .spike(spike_b), .wrap(wrap_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of instance A (spec step rule, seed store, wrap,
    // spike, handshake), expressed per channel with plain arrays.
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] lstep(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] nz(input logic [W-1:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

    logic [W-1:0] m_state [N];
    logic [W-1:0] m_seed  [N];
    logic [N-1:0] m_spike, m_wrap;
    logic         m_ready;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] <= W'(i + 1);
                m_seed[i]  <= W'(i + 1);
            end
            m_spike <= '0;
            m_wrap  <= '0;
            m_ready <= 1'b1;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_ready <= !(load_valid && m_ready);
            for (int i = 0; i < N; i++) begin
                m_spike[i] <= en && (m_state[i] < thresh[i*W +: W]);
                if (load_valid && m_ready && (int'(load_ch) == i)) begin
                    m_state[i] <= nz(load_seed);
                    m_seed[i]  <= nz(load_seed);
                    m_wrap[i]  <= 1'b0;
                end else if (en) begin
                    m_state[i] <= lstep(m_state[i]);
                    m_wrap[i]  <= (lstep(m_state[i]) == m_seed[i]);
                end else begin
                    m_wrap[i]  <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < N; i++)
                chk($sformatf("model_value%0d", i), 64'(value[i*W +: W]), 64'(m_state[i]));
            chk("model_spike", 64'(spike), 64'(m_spike));
            chk("model_wrap",  64'(wrap),  64'(m_wrap));
            chk("model_ready", 64'(load_ready), 64'(m_ready));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    bit           seen [65536];
    logic [3:0]   b_seq [15];
    logic [W-1:0] v;
    int           dups, wraps, wrap_bad, spk0, spkb, wb0, wb1;

    initial begin
        b_seq = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                  4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
        rst = 1'b1; en = 1'b0; en_b = 1'b0; load_valid = 1'b0;
        load_ch = 2'd0; load_seed = '0; thresh = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_value_a", 64'(value), 64'h0003_0002_0001);
        chk("reset_value_b", 64'(value_b), 64'h21);
        chk("reset_ready",   64'(load_ready), 64'd1);
        chk("reset_ready_b", 64'(load_ready_b), 64'd1);
        chk("reset_spike",   64'(spike), 64'd0);
        chk("reset_wrap",    64'(wrap), 64'd0);

        // Full period of channel 0 (16-bit maximal polynomial)
        en = 1'b1; dups = 0; wraps = 0; wrap_bad = 0;
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        for (int n = 1; n <= 65535; n++) begin
            tick();
            v = value[15:0];
            if (n == 1) chk("first_step", 64'(v), 64'hB400);
            if (n == 2) chk("second_step", 64'(v), 64'h5A00);
            if (v == '0 || seen[v]) dups++;
            seen[v] = 1'b1;
            if (wrap[0]) begin
                wraps++;
                if (v != 16'h0001) wrap_bad++;
            end
        end
        chk("period_dups_or_zero", 64'(dups), 64'd0);
        chk("period_wrap_count",   64'(wraps), 64'd1);
        chk("period_wrap_at_seed", 64'(wrap_bad), 64'd0);
        chk("period_end_value",    64'(value), 64'h0003_0002_0001);

        // Zero-seed load on channel 2 while stepping
        load_valid = 1'b1; load_ch = 2'd2; load_seed = 16'h0000;
        tick();
        load_valid = 1'b0;
        chk("zload_ch2",   64'(value[47:32]), 64'h0001);
        chk("zload_ch0",   64'(value[15:0]),  64'hB400);
        chk("zload_ready", 64'(load_ready), 64'd0);
        chk("zload_wrap2", 64'(wrap[2]), 64'd0);
        tick();
        chk("zload_resume", 64'(value[47:32]), 64'hB400);
        chk("zload_ready1", 64'(load_ready), 64'd1);

        // Request held for two cycles: only the first is accepted
        load_valid = 1'b1; load_ch = 2'd0; load_seed = 16'h00FF;
        tick();
        chk("hold_first", 64'(value[15:0]), 64'h00FF);
        tick();
        load_valid = 1'b0;
        chk("hold_second", 64'(value[15:0]), 64'hB47F);
        chk("hold_ready",  64'(load_ready), 64'd1);

        // Out-of-range channel: handshake completes, no state change
        en = 1'b0; load_valid = 1'b1; load_ch = 2'd3; load_seed = 16'h1111;
        tick();
        load_valid = 1'b0;
        chk("oor_ready", 64'(load_ready), 64'd0);
        chk("oor_ch0",   64'(value[15:0]), 64'hB47F);

        // Spike thresholds: ch0 thresh=0, ch1 all-ones
        thresh = {16'h0000, 16'hFFFF, 16'h0000};
        en = 1'b1; spk0 = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (spike[0]) spk0++;
        end
        chk("spike_thresh0", 64'(spk0), 64'd0);
        load_valid = 1'b1; load_ch = 2'd1; load_seed = 16'hFFFF;
        tick();
        load_valid = 1'b0;
        chk("spike_allones_val", 64'(value[31:16]), 64'hFFFF);
        tick();
        chk("spike_at_allones", 64'(spike[1]), 64'd0);
        chk("step_from_allones", 64'(value[31:16]), 64'hCBFF);
        tick();
        chk("spike_after_allones", 64'(spike[1]), 64'd1);
        en = 1'b0;
        tick();
        chk("spike_en0", 64'(spike), 64'd0);
        thresh = '0;

        // 4-bit instance: period 15, two wraps per channel in 30 steps
        en_b = 1'b1; wb0 = 0; wb1 = 0; spkb = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n <= 15) chk($sformatf("b_ch0_step%0d", n), 64'(value_b[3:0]), 64'(b_seq[n-1]));
            if (n == 1)  chk("b_ch1_step1", 64'(value_b[7:4]), 64'h1);
            if (n == 15) chk("b_ch1_period", 64'(value_b[7:4]), 64'h2);
            if (wrap_b[0]) wb0++;
            if (wrap_b[1]) wb1++;
            if (spike_b != 2'b00) spkb++;
        end
        en_b = 1'b0;
        chk("b_wrap0_count", 64'(wb0), 64'd2);
        chk("b_wrap1_count", 64'(wb1), 64'd2);
        chk("b_end_value",   64'(value_b), 64'h21);
        chk("b_no_spike",    64'(spkb), 64'd0);

        // Load ch1, run, then reset with a load pending
        load_valid = 1'b1; load_ch = 2'd1; load_seed = 16'h1234;
        tick();
        load_valid = 1'b0;
        chk("seed1234", 64'(value[31:16]), 64'h1234);
        en = 1'b1;
        for (int n = 0; n < 50; n++) tick();
        rst = 1'b1; load_valid = 1'b1; load_ch = 2'd1; load_seed = 16'h5555;
        tick();
        rst = 1'b0; load_valid = 1'b0; en = 1'b0;
        chk("rst_value",  64'(value), 64'h0003_0002_0001);
        chk("rst_ready",  64'(load_ready), 64'd1);
        chk("rst_spike",  64'(spike), 64'd0);
        tick();
        chk("rst_hold", 64'(value), 64'h0003_0002_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
